// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce FSM state encoding and counter width helper
package btn_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, async active-low clear
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  // shift the raw input through two flops to settle metastability
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, m} <= 2'b00;
    else        {q, m} <= {m, d};
endmodule

// File: rtl/button_pulse_gen.sv
// button_pulse_gen: debounced one-shot pulse from a bouncing button; BTN_REPEAT_EN adds hold-to-repeat
module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int DB_CYCLES  = 1000000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse,
  output logic level,
  output logic busy
);
  localparam int CNT_W = cnt_w(DB_CYCLES, REP_DELAY, REP_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REP_PERIOD - 1);
  logic [CNT_W-1:0] rcnt;
  logic rep;
`endif
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic btn_sync;
  sync_2ff u_sync (.clk(clk), .reset(reset), .d(btn_in), .q(btn_sync));
  // debounce FSM; level and busy are registered alongside each state change
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
      busy  <= 1'b0;
`ifdef BTN_REPEAT_EN
      rcnt  <= '0;
      rep   <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE:
          if (btn_sync) begin
            state <= PRESS_WAIT;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        PRESS_WAIT:
          if (!btn_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= HELD;
            busy  <= 1'b0;
            level <= 1'b1;
            pulse <= 1'b1;
            cnt   <= '0;
`ifdef BTN_REPEAT_EN
            rcnt  <= '0;
            rep   <= 1'b0;
`endif
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!btn_sync) begin
            state <= RELEASE_WAIT;
            busy  <= 1'b1;
            cnt   <= '0;
          end
`ifdef BTN_REPEAT_EN
          else if (rcnt == (rep ? RP_LAST : RD_LAST)) begin
            pulse <= 1'b1;
            rcnt  <= '0;
            rep   <= 1'b1;
          end else rcnt <= rcnt + 1'b1;
`endif
        RELEASE_WAIT:
          if (btn_sync) begin
            state <= HELD;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
`ifdef BTN_REPEAT_EN
            rcnt  <= '0;
            rep   <= 1'b0;
`endif
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen: scoreboard bench; stimulus queues expected pulse cycles, monitor pops on each pulse
module tb_button_pulse_gen;
  localparam int DB = 4, RD = 10, RP = 5;
  logic clk = 1'b0, reset = 1'b0, btn_in = 1'b0;
  logic pulse, level, busy;
  logic [2:0] cnt3;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int exp_q[$];
  int seq[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  button_pulse_gen #(.DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .pulse(pulse), .level(level), .busy(busy)
  );
  always #5 clk = ~clk;
  // edge index: the value of cyc at a negedge is the number of the preceding posedge
  always @(posedge clk) cyc <= cyc + 1;
  // stand-in for the downstream 3-bit bin_counter enabled by pulse
  always @(posedge clk or negedge reset)
    if (!reset) cnt3 <= '0;
    else if (pulse) cnt3 <= cnt3 + 1'b1;
  // monitor: every pulse must match the oldest expected pulse cycle
  always @(negedge clk) begin
    int e;
    if (pulse) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: pulse at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          n_bad++;
          $display("FAIL pulse_time: pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int k, j, p;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      btn_in = ~btn_in;
      chk("rst_pulse", pulse, 0);
      chk("rst_level", level, 0);
      chk("rst_busy", busy, 0);
    end
    @(negedge clk);
    btn_in = 1'b0;
    reset = 1'b1;
    at(cyc + 3);
    btn_in = 1'b1;
    k = cyc + 1;
    exp_q.push_back(k + 2 + DB);
    at(k + 3); chk("press_busy", busy, 1); chk("press_level_pre", level, 0);
    at(k + 5); chk("press_level_late", level, 0);
    at(k + 6); chk("press_level", level, 1); chk("press_busy_done", busy, 0);
    at(k + 8);
    btn_in = 1'b0;
    j = cyc + 1;
    at(j + 2); chk("rel_busy", busy, 1); chk("rel_level_hold", level, 1);
    at(j + 5); chk("rel_level_pre", level, 1);
    at(j + 6); chk("rel_level", level, 0); chk("rel_busy_done", busy, 0);
    at(cyc + 2);
    btn_in = 1'b1;
    k = cyc + 1;
    at(k + 2); btn_in = 1'b0;
    at(k + 3); chk("bnc_busy1", busy, 1); btn_in = 1'b1;
    at(k + 5); chk("bnc_idle1", busy, 0); btn_in = 1'b0;
    at(k + 6); chk("bnc_busy2", busy, 1);
    at(k + 8); chk("bnc_idle2", busy, 0);
    at(k + 10); chk("bnc_busy_end", busy, 0); chk("bnc_level", level, 0);
    at(cyc + 2);
    btn_in = 1'b1;
    k = cyc + 1;
    exp_q.push_back(k + 2 + DB);
    at(k + 8); btn_in = 1'b0;
    j = cyc + 1;
    at(j + 1); btn_in = 1'b1;
    at(j + 2); chk("glt_busy", busy, 1); chk("glt_level", level, 1);
    at(j + 3); btn_in = 1'b0;
    at(j + 4); chk("glt_held_busy", busy, 0); chk("glt_held_level", level, 1);
    at(j + 9); chk("glt_rel_pre", level, 1);
    at(j + 10); chk("glt_rel_level", level, 0); chk("glt_rel_busy", busy, 0);
    at(cyc + 2);
    btn_in = 1'b1;
    k = cyc + 1;
    at(k + 3); chk("mid_busy", busy, 1);
    #1 reset = 1'b0;
    #1 chk("mid_rst_busy", busy, 0); chk("mid_rst_level", level, 0); chk("mid_rst_pulse", pulse, 0);
    at(k + 8); chk("mid_hold_busy", busy, 0); chk("mid_hold_level", level, 0);
    reset = 1'b1;
    k = cyc + 1;
    exp_q.push_back(k + 2 + DB);
    at(k + 6); chk("rstrel_level", level, 1);
    at(k + 8); btn_in = 1'b0;
    at(k + 15); chk("rstrel_released", level, 0);
    at(cyc + 2);
    btn_in = 1'b1;
    k = cyc + 1;
    p = k + 2 + DB;
    exp_q.push_back(p);
`ifdef BTN_REPEAT_EN
    for (int t = RD; t <= 30; t += RP) exp_q.push_back(p + t);
`endif
    at(p + 30); btn_in = 1'b0;
    j = cyc + 1;
    at(j + 5); chk("rep_level_hold", level, 1);
    at(j + 6); chk("rep_level_rel", level, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      at(cyc + 2);
      btn_in = 1'b1;
      k = cyc + 1;
      exp_q.push_back(k + 2 + DB);
      at(k + 8); btn_in = 1'b0;
      at(k + 15);
      chk("count", cnt3, seq[i]);
    end
    at(cyc + 3);
    chk("pending_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
